// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// reg_file_sb : integer register file with write-to-read bypass and a
//               busy-bit scoreboard for long-latency writers
// Revision    : 1.0
// ============================================================================
module reg_file_sb #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W+AW:0] wb_in,
  input  logic [AW-1:0]     rs1_addr,
  input  logic [AW-1:0]     rs2_addr,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_rd,
  input  logic              flush,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              stall,
  output logic [AW:0]       busy_cnt
);

  logic [DATA_W-1:0] wb_data_w;
  logic [AW-1:0]     wb_rd_w;
  logic              wb_en_w;
  logic              wr_w;

  assign {wb_data_w, wb_rd_w, wb_en_w} = wb_in;
  assign wr_w = wb_en_w && (wb_rd_w != '0);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_w) begin
      regs_q[wb_rd_w] <= wb_data_w;
    end
  end

  logic byp1_w;
  logic byp2_w;

  assign byp1_w = BYPASS && wr_w && (wb_rd_w == rs1_addr);
  assign byp2_w = BYPASS && wr_w && (wb_rd_w == rs2_addr);

  // Reset also masks the bypass path so the ports read zero while rst is high.
  assign rs1_data = (rst || rs1_addr == '0) ? '0 : (byp1_w ? wb_data_w : regs_q[rs1_addr]);
  assign rs2_data = (rst || rs2_addr == '0) ? '0 : (byp2_w ? wb_data_w : regs_q[rs2_addr]);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [AW:0]         busy_cnt_q;
  logic [AW:0]         busy_cnt_d;

  // A new producer's set is applied after the retiring writer's clear so it wins.
  always_comb begin
    busy_d     = busy_q;
    busy_cnt_d = '0;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_w) busy_d[wb_rd_w] = 1'b0;
      if (sb_set && (sb_rd != '0)) busy_d[sb_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_cnt_d = busy_cnt_d + (AW+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  logic hz1_w;
  logic hz2_w;

  assign hz1_w = rs1_used && (rs1_addr != '0) && busy_q[rs1_addr] && !byp1_w;
  assign hz2_w = rs2_used && (rs2_addr != '0) && busy_q[rs2_addr] && !byp2_w;

  assign stall    = hz1_w | hz2_w;
  assign busy_cnt = busy_cnt_q;

endmodule
`default_nettype wire
